// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter arbiter: FSM encoding and default operand width.
package counter_ctrl_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared interval counter handed to one of two requesters at a time.
//   state | meaning
//   IDLE  | counter unowned, arbitrate on req
//   COUNT | owner's interval running, q increments each clock
//   DONE  | one-cycle done pulse to the finished owner, q held
module counter_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  output logic [1:0]   gnt,
  output logic [W-1:0] q,
  output logic         busy,
  output logic [1:0]   done
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [1:0]   r_gnt;
  logic [1:0]   r_done;
  logic [W-1:0] r_q;
  logic [W-1:0] r_len;
  logic         r_last;

  logic [1:0]   w_win;
  logic [W-1:0] w_win_len;
  logic [W-1:0] w_tc;
  logic         w_own;

  rr_arb2 u_rr_arb2 (
    .i_req  (req),
    .i_last (r_last),
    .o_gnt  (w_win)
  );

  assign w_win_len = w_win[1] ? len1 : len0;
  assign w_own     = r_gnt[1];
  // len of 0 wraps to all-ones here, giving a full 2^W-cycle interval
  assign w_tc      = r_len - ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_q     <= '0;
      r_len   <= '0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 2'b00;
          if (req != 2'b00) begin
            r_state <= COUNT;
            r_gnt   <= w_win;
            r_len   <= w_win_len;
            r_q     <= '0;
          end
        end
        COUNT: begin
          if (!req[w_own]) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= w_own;
          end else if (r_q == w_tc) begin
            r_state <= DONE;
            r_gnt   <= 2'b00;
            r_done  <= r_gnt;
            r_last  <= w_own;
          end else begin
            r_q <= r_q + ONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 2'b00;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_done  <= 2'b00;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign q    = r_q;
  assign busy = (r_state == COUNT);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: grant, count, done, round-robin, abort and reset cases.
module tb_counter_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic [3:0] q;
  logic       busy;
  logic [1:0] done;

  int n_cmp = 0;
  int n_err = 0;

  counter_arbiter #(.W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then check gnt/done exclusivity and one-hotness
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl", {31'd0, (gnt != 2'b00) && (done != 2'b00)}, 32'd0);
    chk("onehot", {31'd0, (gnt == 2'b11) || (done == 2'b11)}, 32'd0);
  endtask

  logic [1:0] exp_g [0:10];
  logic [1:0] exp_d [0:10];
  logic [3:0] exp_q [0:10];

  initial begin
    reset = 1'b0;
    req   = 2'b00;
    len0  = 4'd0;
    len1  = 4'd0;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_q", q, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 2'b00);
    tick();
    tick();
    reset = 1'b1;

    // basic interval: len0=3
    req = 2'b01; len0 = 4'd3;
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_q0", q, 4'd0);
    tick(); chk("t1_q1", q, 4'd1);
    tick(); chk("t1_q2", q, 4'd2);
    tick();
    chk("t1_done", done, 2'b01);
    chk("t1_gnt_dn", gnt, 2'b00);
    chk("t1_q_hold", q, 4'd2);
    chk("t1_busy_dn", busy, 1'b0);
    req = 2'b00;
    tick();
    chk("t1_done_clr", done, 2'b00);
    chk("t1_gnt_idle", gnt, 2'b00);

    // len1=0 runs full 16 counts
    req = 2'b10; len1 = 4'd0;
    tick();
    chk("t3_gnt", gnt, 2'b10);
    for (int i = 0; i < 16; i++) begin
      chk("t3_q", q, i);
      chk("t3_busy", busy, 1'b1);
      chk("t3_nodone", done, 2'b00);
      tick();
    end
    chk("t3_done", done, 2'b10);
    chk("t3_q_hold", q, 4'd15);
    chk("t3_busy_dn", busy, 1'b0);
    req = 2'b00;
    tick();
    chk("t3_done_clr", done, 2'b00);

    // both held: grants alternate with one IDLE cycle between
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    exp_d = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    exp_q = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    req = 2'b11; len0 = 4'd2; len1 = 4'd2;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t2_gnt", gnt, exp_g[i]);
      chk("t2_done", done, exp_d[i]);
      chk("t2_q", q, exp_q[i]);
    end
    req = 2'b00;
    tick();

    // abort at q=4, then tie goes to requester 1
    req = 2'b01; len0 = 4'd8;
    tick();
    chk("t4_gnt", gnt, 2'b01);
    repeat (4) tick();
    chk("t4_q4", q, 4'd4);
    req = 2'b00;
    tick();
    chk("t4_gnt_ab", gnt, 2'b00);
    chk("t4_busy_ab", busy, 1'b0);
    chk("t4_q_hold", q, 4'd4);
    chk("t4_nodone", done, 2'b00);
    tick();
    chk("t4_nodone2", done, 2'b00);
    req = 2'b11;
    tick();
    chk("t4_rr", gnt, 2'b10);
    req = 2'b00;
    tick();
    chk("t4_gnt_ab2", gnt, 2'b00);

    // reset between edges mid-count
    req = 2'b01; len0 = 4'd8;
    tick();
    repeat (5) tick();
    chk("t5_q5", q, 4'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_q", q, 4'd0);
    chk("t5_gnt", gnt, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 2'b00);
    tick();
    chk("t5_done2", done, 2'b00);
    chk("t5_gnt2", gnt, 2'b00);
    req = 2'b00;
    reset = 1'b1;

    // tie after reset goes to 0; len change after grant is ignored
    req = 2'b11; len0 = 4'd4; len1 = 4'd7;
    tick();
    chk("t6_gnt", gnt, 2'b01);
    len0 = 4'd9;
    tick(); chk("t6_q1", q, 4'd1);
    tick(); chk("t6_q2", q, 4'd2);
    tick(); chk("t6_q3", q, 4'd3);
    tick();
    chk("t6_done", done, 2'b01);
    chk("t6_q_hold", q, 4'd3);
    req = 2'b00;
    tick();
    chk("t6_done_clr", done, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter: W, default 4, width of count and length operands.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: req  input  2  per-requester request for a timed count interval; level, held until done.
REQ-005 The block SHALL have port: len0  input  W  requester 0 interval length in ticks; 0 means 2^W.
REQ-006 The block SHALL have port: len1  input  W  requester 1 interval length in ticks; 0 means 2^W.
REQ-007 The block SHALL have port: gnt  output  2  one-hot owner of the shared counter; 00 when unowned.
REQ-008 The block SHALL have port: q  output  W  current shared count value.
REQ-009 The block SHALL have port: busy  output  1  high in COUNT state.
REQ-010 The block SHALL have port: done  output  2  one-cycle pulse to the owner at interval completion.

Function
REQ-011 The FSM SHALL have states IDLE, COUNT and DONE.
REQ-012 In IDLE with req!=00, the next edge SHALL enter COUNT, set gnt to the winner, capture the winner's len into an internal register, and clear q to 0.
REQ-013 When both requesters are active in IDLE, the winner SHALL be the requester not granted last; after reset, requester 0 wins.
REQ-014 In COUNT, q SHALL increment by 1 per clock, modulo 2^W.
REQ-015 When q equals (captured len - 1) mod 2^W, the next edge SHALL enter DONE; q SHALL reach that value exactly len cycles after the grant edge (2^W cycles for len=0).
REQ-016 In DONE, done[owner] SHALL be 1 for exactly one cycle, gnt SHALL be 00, q SHALL hold its value, and the next edge SHALL enter IDLE.
REQ-017 If req[owner] drops during COUNT, the next edge SHALL enter IDLE with gnt=00, q held and no done pulse (abort).
REQ-018 The last-granted pointer SHALL update on entering DONE and on abort.
REQ-019 Changes to len0/len1 after the grant edge SHALL NOT affect the running interval.
REQ-020 Requests arriving in COUNT or DONE SHALL be ignored until IDLE; there SHALL be at least one IDLE cycle between consecutive grants.
REQ-021 gnt and done SHALL be registered outputs, never both nonzero in the same cycle, and never more than one bit set.

Reset
REQ-022 While reset=0, the block SHALL immediately force state=IDLE, gnt=00, done=00, busy=0, q=0, pointer=requester 1 last granted (so 0 wins next), regardless of clk.
REQ-023 Reset asserted mid-COUNT SHALL abort the interval with no done pulse; operation resumes on the first posedge after reset=1.

Structure
REQ-024 A shared package counter_ctrl_pkg SHALL hold the state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the default W.
REQ-025 The round-robin choice SHALL be one sub-module, rr_arb2 (inputs req[1:0] and last pointer; output one-hot grant), combinational.
REQ-026 The count register, captured length, FSM and pointer SHALL reside in counter_arbiter.

Verification
REQ-027 The bench SHALL cover: reset low 2 cycles, then req=01, len0=3 -> gnt=01 next edge, q=0,1,2, done=01 for one cycle, then gnt=00.
REQ-028 The bench SHALL cover: req=11 held, len0=2, len1=2 -> grants alternate 01,10,01 with one IDLE cycle between each; done pulses match each owner.
REQ-029 The bench SHALL cover: req=10, len1=0 -> q runs 0..15 (16 cycles busy), wraps, done=10 once.
REQ-030 The bench SHALL cover: req=01, len0=8, drop req[0] at q=4 -> IDLE next edge, no done, q holds 4; the following req=11 grants requester 1.
REQ-031 The bench SHALL cover: reset driven low mid-COUNT between clock edges (q=5) -> q=0, gnt=00, busy=0 immediately, no done.
REQ-032 The bench SHALL cover: len0 changed from 4 to 9 one cycle after grant -> interval still completes after 4 counts.
